// File: rtl/riscuinho_pkg.sv
// riscuinho_pkg: shared loader state encoding, error codes and frame constants
package riscuinho_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/loader_word_packer.sv
// loader_word_packer: assembles little-endian bytes into words and keeps a running XOR
module loader_word_packer #(
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              strobe,
    input  logic [7:0]        byte_in,
    output logic              word_ready,
    output logic [STEP*8-1:0] word,
    output logic [7:0]        xor_out
);

    localparam int W  = STEP * 8;
    localparam int IW = (STEP > 1) ? $clog2(STEP) : 1;

    logic [IW-1:0] idx;
    logic [W-1:0]  sh;

    // word already includes byte_in so the caller can latch a complete word on the last byte's edge
    assign word       = W'({byte_in, sh} >> 8);
    assign word_ready = strobe && idx == IW'(STEP - 1);

    // Byte index, shift register and checksum restart on clear and advance on each strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            sh      <= '0;
            xor_out <= '0;
        end else if (clear) begin
            idx     <= '0;
            sh      <= '0;
            xor_out <= '0;
        end else if (strobe) begin
            idx     <= word_ready ? '0 : idx + 1'b1;
            sh      <= word;
            xor_out <= xor_out ^ byte_in;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader that writes instruction words into program memory
module program_loader
    import riscuinho_pkg::*;
#(
    parameter int         INSTR_ADDR_WIDTH = 20,
    parameter int         STEP             = 4,
    parameter int         LEN_BYTES        = 3,
    parameter logic [7:0] MAGIC            = DEFAULT_MAGIC,
    parameter int         TIMEOUT          = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        pgm,
    output logic [INSTR_ADDR_WIDTH-1:0] addr,
    output logic [STEP*8-1:0]           data,
    output logic                        core_hold,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  err_code
);

    localparam int AW  = INSTR_ADDR_WIDTH;
    localparam int W   = STEP * 8;
    localparam int LW  = LEN_BYTES * 8;
    localparam int CW  = (LW > AW + 1) ? LW : AW + 1;
    localparam int LCW = $clog2(LEN_BYTES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SIZE_W = CW'(1) << AW;

    loader_state_t state;
    logic [LW-1:0]  len;
    logic [LW-1:0]  len_next;
    logic [CW-1:0]  len_w;
    logic [LCW-1:0] lcnt;
    logic [AW:0]    widx;
    logic [TW-1:0]  tmo;
    logic           acc;
    logic           strobe;
    logic           clear;
    logic           word_ready;
    logic [W-1:0]   word;
    logic [7:0]     xsum;

    assign acc      = in_valid && in_ready;
    assign strobe   = acc && state == S_DATA;
    assign clear    = acc && state == S_IDLE && in_data == MAGIC;
    assign len_next = LW'({in_data, len} >> 8);
    assign len_w    = CW'(len_next);

    loader_word_packer #(
        .STEP(STEP)
    ) packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .strobe    (strobe),
        .byte_in   (in_data),
        .word_ready(word_ready),
        .word      (word),
        .xor_out   (xsum)
    );

    // Frame sequencer; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            pgm       <= 1'b0;
            addr      <= '0;
            data      <= '0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            len       <= '0;
            lcnt      <= '0;
            widx      <= '0;
            tmo       <= '0;
        end else begin
            pgm  <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    tmo      <= '0;
                    lcnt     <= '0;
                    widx     <= '0;
                    if (clear) begin
                        state     <= S_LEN;
                        core_hold <= 1'b1;
                    end
                end
                S_WRITE: begin
                    in_ready <= 1'b1;
                    widx     <= widx + 1'b1;
                    state    <= (CW'(widx + 1'b1) == CW'(len)) ? S_CSUM : S_DATA;
                end
                S_DONE, S_ERR: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    if (acc) begin
                        tmo <= '0;
                        if (state == S_LEN) begin
                            len  <= len_next;
                            lcnt <= lcnt + 1'b1;
                            if (lcnt == LCW'(LEN_BYTES - 1)) begin
                                if (len_w > SIZE_W) begin
                                    state     <= S_ERR;
                                    err       <= 1'b1;
                                    err_code  <= ERR_LEN;
                                    core_hold <= 1'b0;
                                    in_ready  <= 1'b0;
                                end else begin
                                    state <= (len_w == '0) ? S_CSUM : S_DATA;
                                end
                            end
                        end else if (state == S_DATA) begin
                            if (word_ready) begin
                                state    <= S_WRITE;
                                pgm      <= 1'b1;
                                addr     <= widx[AW-1:0];
                                data     <= word;
                                in_ready <= 1'b0;
                            end
                        end else if (in_data == xsum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                            in_ready  <= 1'b0;
                        end else begin
                            state     <= S_ERR;
                            err       <= 1'b1;
                            err_code  <= ERR_CSUM;
                            core_hold <= 1'b0;
                            in_ready  <= 1'b0;
                        end
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        state     <= S_ERR;
                        err       <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        core_hold <= 1'b0;
                        in_ready  <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
